// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// tmds_channel_decoder: finds the TMDS symbol boundary from control-token runs and decodes one HDMI channel.
// Optional blanking-interval counter enabled by `define TMDS_BLANK_COUNT_EN. Rev 1.0
module tmds_channel_decoder #(
  parameter int LOCK_RUN      = 8,
  parameter int SEARCH_CYCLES = 4096,
  parameter int LOSS_CYCLES   = 65536
) (
  input  logic        PixelClock,
  input  logic        ResetN,
  input  logic [9:0]  RawWord,
  output logic [7:0]  PixelData,
  output logic [1:0]  Control,
  output logic        DataEnable,
  output logic        Locked,
`ifdef TMDS_BLANK_COUNT_EN
  output logic [15:0] BlankCount,
`endif
  output logic [3:0]  Offset
);

  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int SRCH_W = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int LOSS_W = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_RUN);
  localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CYCLES - 1);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [9:0]        prev_word;
  logic [9:0]        aligned;
  logic [19:0]       window;
  logic [9:0]        aligned_next;
  logic              is_token;
  logic [1:0]        token_code;
  logic [7:0]        data_src;
  logic [7:0]        data_dec;
  logic [RUN_W-1:0]  run_cnt;
  logic [RUN_W-1:0]  run_next;
  logic              run_hit;
  logic [SRCH_W-1:0] search_cnt;
  logic              search_done;
  logic [LOSS_W-1:0] loss_cnt;
  logic              loss_done;
  logic [0:0]        state;
  logic [0:0]        state_next;
  logic              lock_next;
  logic              de_next;
  logic [7:0]        pixel_next;
  logic [1:0]        control_next;

  // Bit 0 of the older word arrives first, so offset 0 selects the previous word whole.
  assign window       = {RawWord, prev_word};
  assign aligned_next = 10'(window >> Offset);

  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) begin
      prev_word <= '0;
      aligned   <= '0;
    end else begin
      prev_word <= RawWord;
      aligned   <= aligned_next;
    end
  end

  always_comb begin
    is_token   = 1'b1;
    token_code = 2'b00;
    case (aligned)
      10'h354: token_code = 2'b00;
      10'h0AB: token_code = 2'b01;
      10'h154: token_code = 2'b10;
      10'h2AB: token_code = 2'b11;
      default: is_token   = 1'b0;
    endcase
  end

  assign data_src = aligned[7:0] ^ {8{aligned[9]}};

  always_comb begin
    data_dec    = '0;
    data_dec[0] = data_src[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = aligned[8] ? (data_src[i] ^ data_src[i-1]) : ~(data_src[i] ^ data_src[i-1]);
    end
  end

  // A hit is the cycle a run first reaches LOCK_RUN; a saturated run does not re-trigger.
  assign run_next    = !is_token ? '0 : (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
  assign run_hit     = (run_cnt != RUN_MAX) && (run_next == RUN_MAX);
  assign search_done = (search_cnt == SRCH_LAST);
  assign loss_done   = (loss_cnt == LOSS_LAST);

  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) state <= HUNT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (run_hit) state_next = LOCKED;
      LOCKED:  if (loss_done && !run_hit) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    lock_next    = (state_next == LOCKED);
    de_next      = lock_next && !is_token;
    pixel_next   = de_next ? data_dec : '0;
    control_next = (lock_next && is_token) ? token_code : '0;
  end

  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) begin
      PixelData  <= '0;
      Control    <= '0;
      DataEnable <= 1'b0;
      Locked     <= 1'b0;
    end else begin
      PixelData  <= pixel_next;
      Control    <= control_next;
      DataEnable <= de_next;
      Locked     <= lock_next;
    end
  end

  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) begin
      run_cnt    <= '0;
      search_cnt <= '0;
      loss_cnt   <= '0;
      Offset     <= '0;
    end else if (state == HUNT) begin
      if (run_hit) begin
        run_cnt    <= run_next;
        search_cnt <= '0;
        loss_cnt   <= '0;
      end else if (search_done) begin
        run_cnt    <= '0;
        search_cnt <= '0;
        Offset     <= (Offset == 4'd9) ? 4'd0 : Offset + 4'd1;
      end else begin
        run_cnt    <= run_next;
        search_cnt <= search_cnt + SRCH_W'(1);
      end
    end else begin
      run_cnt    <= run_next;
      search_cnt <= '0;
      loss_cnt   <= (run_hit || loss_done) ? '0 : loss_cnt + LOSS_W'(1);
    end
  end

`ifdef TMDS_BLANK_COUNT_EN
  logic last_was_data;

  always_ff @(posedge PixelClock or negedge ResetN) begin
    if (!ResetN) begin
      last_was_data <= 1'b0;
      BlankCount    <= '0;
    end else begin
      last_was_data <= !is_token;
      if (!lock_next)
        BlankCount <= '0;
      else if (is_token && last_was_data && (BlankCount != 16'hFFFF))
        BlankCount <= BlankCount + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// tb_tmds_channel_decoder: random and directed TMDS streams checked against a stream-level reference model.
// Build with +define+TMDS_BLANK_COUNT_EN to cover the blanking counter. Rev 1.0
module tb_tmds_channel_decoder;

  localparam int LOCK_RUN      = 8;
  localparam int SEARCH_CYCLES = 16;
  localparam int LOSS_CYCLES   = 64;

  logic        clk;
  logic        rst_n;
  logic [9:0]  raw_word;
  logic [7:0]  pixel_data;
  logic [1:0]  control;
  logic        data_enable;
  logic        locked;
  logic [3:0]  offset;
`ifdef TMDS_BLANK_COUNT_EN
  logic [15:0] blank_count;
`endif

  tmds_channel_decoder #(
    .LOCK_RUN      (LOCK_RUN),
    .SEARCH_CYCLES (SEARCH_CYCLES),
    .LOSS_CYCLES   (LOSS_CYCLES)
  ) dut (
    .PixelClock (clk),
    .ResetN     (rst_n),
    .RawWord    (raw_word),
    .PixelData  (pixel_data),
    .Control    (control),
    .DataEnable (data_enable),
    .Locked     (locked),
`ifdef TMDS_BLANK_COUNT_EN
    .BlankCount (blank_count),
`endif
    .Offset     (offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int tokens [4] = '{'h354, 'h0AB, 'h154, 'h2AB};

  // Reference model state: previous raw word, aligned word in flight, counters, lock flag.
  int m_prev, m_aligned, m_run, m_search, m_loss, m_off, m_blank, m_last_data;
  bit m_locked;
  int e_de, e_pd, e_ctl;

  // Stream generator: symbols start at bit cur_shift of the raw word stream.
  int cur_shift;
  int last_sym;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int tok_code(input int w);
    for (int k = 0; k < 4; k++) if (w == tokens[k]) return k;
    return -1;
  endfunction

  function automatic int tmds_decode(input int q);
    int x, d;
    x = ((q >> 9) & 1) ? (~q & 'hFF) : (q & 'hFF);
    d = (x ^ (x << 1)) & 'hFF;
    if (((q >> 8) & 1) == 0) d = d ^ 'hFE;
    return d;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_aligned = 0; m_run = 0; m_search = 0; m_loss = 0;
    m_off = 0; m_blank = 0; m_last_data = 0; m_locked = 0;
    e_de = 0; e_pd = 0; e_ctl = 0;
    last_sym = 0;
  endtask

  task automatic model_step(input int w);
    int code, run_next, new_al;
    bit tok, hit;
    code     = tok_code(m_aligned);
    tok      = (code >= 0);
    run_next = tok ? ((m_run < LOCK_RUN) ? m_run + 1 : LOCK_RUN) : 0;
    hit      = (m_run != LOCK_RUN) && (run_next == LOCK_RUN);
    new_al   = ((((w & 'h3FF) << 10) | m_prev) >> m_off) & 'h3FF;
    if (!m_locked) begin
      if (hit) begin
        m_locked = 1; m_loss = 0; m_search = 0; m_run = run_next;
      end else if (m_search == SEARCH_CYCLES - 1) begin
        m_search = 0; m_run = 0; m_off = (m_off + 1) % 10;
      end else begin
        m_search++; m_run = run_next;
      end
    end else begin
      m_run = run_next;
      if (hit) m_loss = 0;
      else if (m_loss == LOSS_CYCLES - 1) begin
        m_locked = 0; m_search = 0; m_loss = 0;
      end else m_loss++;
    end
    e_de  = (m_locked && !tok) ? 1 : 0;
    e_pd  = e_de ? tmds_decode(m_aligned) : 0;
    e_ctl = (m_locked && tok) ? code : 0;
    if (!m_locked) m_blank = 0;
    else if (tok && m_last_data != 0 && m_blank < 'hFFFF) m_blank++;
    m_last_data = tok ? 0 : 1;
    m_prev      = w & 'h3FF;
    m_aligned   = new_al;
  endtask

  task automatic compare_all();
    check("locked", locked, m_locked);
    check("data_enable", data_enable, e_de);
    check("offset", offset, m_off);
    check("offset_range", (offset < 4'd10), 1);
    if (e_de != 0) check("pixel_data", pixel_data, e_pd);
    if (m_locked && e_de == 0) check("control", control, e_ctl);
    if (!m_locked) begin
      check("hunt_pixel_zero", pixel_data, 0);
      check("hunt_control_zero", control, 0);
    end
`ifdef TMDS_BLANK_COUNT_EN
    check("blank_count", blank_count, m_blank);
`endif
  endtask

  task automatic cycle(input int w);
    raw_word = 10'(w);
    @(posedge clk);
    model_step(w);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_sym(input int sym);
    int raw;
    raw = (((last_sym >> (10 - cur_shift)) | (sym << cur_shift)) & 'h3FF);
    last_sym = sym;
    cycle(raw);
  endtask

  task automatic random_data_sym(output int w);
    w = $urandom_range(0, 1023);
    while (tok_code(w) >= 0) w = $urandom_range(0, 1023);
  endtask

  // Reset is asserted between clock edges so its effect must be visible without a clock.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pixel", pixel_data, 0);
    check("rst_control", control, 0);
    check("rst_de", data_enable, 0);
    check("rst_locked", locked, 0);
    check("rst_offset", offset, 0);
`ifdef TMDS_BLANK_COUNT_EN
    check("rst_blank", blank_count, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_lock(input int sym, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      send_sym(sym);
      if (locked) break;
    end
    check(tag, locked, 1);
  endtask

  initial begin
    int saved_off, n, prev_off, w, tl, dl, code;
    bit saw_wrap;
`ifdef TMDS_BLANK_COUNT_EN
    int b0;
`endif
    rst_n    = 1'b0;
    raw_word = '0;
    cur_shift = 0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Offset-0 stream: lock two cycles after the 8th token, then data 0x100 decodes to 0x00.
    cur_shift = 0;
    for (int i = 0; i < 8; i++) send_sym('h354);
    send_sym('h100);
    send_sym('h100);
    check("t1_locked", locked, 1);
    check("t1_offset", offset, 0);
    send_sym('h100);
    check("t1_de", data_enable, 1);
    check("t1_pixel", pixel_data, 0);

    // Shift 3 with continuous 0x2AB: offset hunts up to 3 and locks there.
    cur_shift = 3;
    apply_reset();
    wait_lock('h2AB, 200, "t2_lock");
    check("t2_offset", offset, 3);
    check("t2_control", control, 3);

    // Idle data long enough to wrap the offset, then tokens at shift 9.
    cur_shift = 9;
    apply_reset();
    saw_wrap = 0;
    prev_off = 0;
    for (int i = 0; i < 170; i++) begin
      send_sym('h100);
      if (prev_off == 9 && offset == 0) saw_wrap = 1;
      prev_off = offset;
    end
    check("t3_wrap", saw_wrap, 1);
    wait_lock('h2AB, 250, "t3_lock");
    check("t3_offset", offset, 9);

    // Runs of only 7 tokens never refresh the loss timer: lock drops after LOSS_CYCLES.
    saved_off = offset;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      send_sym(((i % 8) == 7) ? 'h100 : 'h2AB);
      n++;
      if (!locked) break;
    end
    check("t4_drop_cycle", n, LOSS_CYCLES);
    check("t4_de", data_enable, 0);
    check("t4_offset", offset, saved_off);

    // Asynchronous reset while data is flowing, then relock.
    cur_shift = 0;
    apply_reset();
    wait_lock('h354, 20, "t5_lock");
    for (int i = 0; i < 3; i++) send_sym('h100);
    check("t5_pre_de", data_enable, 1);
    apply_reset();
    wait_lock('h354, 20, "t5_relock");

`ifdef TMDS_BLANK_COUNT_EN
    b0 = blank_count;
    for (int g = 0; g < 3; g++) begin
      send_sym('h100);
      send_sym('h100);
      for (int i = 0; i < 8; i++) send_sym('h154);
    end
    send_sym('h354);
    send_sym('h354);
    check("t6_blank_delta", blank_count - 16'(b0), 3);
`endif

    // Random token/data segments at random symbol shifts.
    for (int sc = 0; sc < 6; sc++) begin
      cur_shift = $urandom_range(0, 9);
      apply_reset();
      n = 0;
      while (n < 400) begin
        tl   = $urandom_range(0, 12);
        code = $urandom_range(0, 3);
        for (int i = 0; i < tl; i++) begin
          send_sym(tokens[($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : code]);
          n++;
        end
        dl = $urandom_range(1, 5);
        for (int i = 0; i < dl; i++) begin
          random_data_sym(w);
          send_sym(w);
          n++;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

- Per-channel HDMI receive stage running on the recovered HDMI pixel clock (the buffered output of the differential clock input buffer).
- Consumes the raw 10-bit TMDS words from the channel deserializer and finds the symbol boundary by hunting for control-token runs.
- Decodes each aligned word into 8-bit pixel data or a 2-bit control code.
- Reports lock status, which drives a board LED alongside the existing clock-activity indicators.

## Interface
Parameters:
- LOCK_RUN, 8: consecutive control tokens required to declare lock.
- SEARCH_CYCLES, 4096: cycles spent at one bit offset before advancing.
- LOSS_CYCLES, 65536: cycles in LOCKED without any LOCK_RUN-long token run before lock is dropped.

Ports (one clock; reset is asynchronous and active-low):
- PixelClock  in  1  recovered HDMI pixel clock; all logic on its rising edge.
- ResetN  in  1  asynchronous active-low reset.
- RawWord  in  10  deserialized TMDS word, new word every cycle, bit 0 received first.
- PixelData  out  8  decoded video data; valid when DataEnable=1.
- Control  out  2  decoded {C1,C0}; valid when DataEnable=0 and Locked=1.
- DataEnable  out  1  aligned word was a data symbol.
- Locked  out  1  symbol alignment established.
- Offset  out  4  current bit-slip offset, 0..9.
- BlankCount  out  16  blanking-interval counter (only with macro).

## Operation
- Alignment window:
  - PrevWord register holds the previous RawWord.
  - Window = {RawWord, PrevWord} (20 bits); Aligned = Window[Offset +: 10].
  - Offset is never outside 0..9.
- Token detect on Aligned:
  - 0x354 gives C=00; 0x0AB gives C=01; 0x154 gives C=10; 0x2AB gives C=11.
  - Any other value is a data symbol.
- Data decode:
  - If q[9]=1, invert q[7:0].
  - d[0]=q[0].
  - For i=1..7: d[i] = q[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- RunCount: increments on each token and saturates at LOCK_RUN; clears on any data symbol.
- FSM state HUNT (reset state):
  - A cycle counter counts to SEARCH_CYCLES-1.
  - On expiry: Offset advances (9 wraps to 0), counter clears, RunCount clears.
  - When RunCount reaches LOCK_RUN: go to LOCKED and clear the loss counter. Offset is frozen.
- FSM state LOCKED:
  - Loss counter increments every cycle.
  - The loss counter clears on each cycle where RunCount transitions to LOCK_RUN.
  - When the loss counter reaches LOSS_CYCLES-1: return to HUNT, keeping the current Offset, with the search counter cleared.
- Simultaneous events:
  - In HUNT, lock on the same cycle as search expiry: lock wins and Offset does not advance.
  - In LOCKED, a run completing on the same cycle as loss expiry: stays LOCKED.
- Outputs while HUNT: DataEnable=0, PixelData=0, Control=0.

## Timing
- Latency is 2 cycles:
  - RawWord is sampled at edge N (PrevWord is captured at the same edge).
  - Aligned and decode are registered at edge N+1.
  - Outputs are valid after edge N+2.
- Locked asserts 1 cycle after the cycle in which RunCount reaches LOCK_RUN, aligned with the outputs of the completing token.
- Locked deasserts, and DataEnable/PixelData/Control go to 0, 1 cycle after loss expiry.
- An Offset change takes effect on the next sampled word; outputs during the 2 following cycles are don't-care, but DataEnable stays 0 because the block is in HUNT.
- Reset (asynchronous, any time, including mid-lock):
  - Outputs: PixelData=0, Control=0, DataEnable=0, Locked=0, Offset=0, BlankCount=0.
  - Internal state: all counters 0, PrevWord=0, FSM=HUNT.

## Configuration
- Macro: TMDS_BLANK_COUNT_EN.
- Defined:
  - BlankCount increments by 1 on each LOCKED-state transition from a data symbol to a token.
  - It saturates at 0xFFFF and clears on reset and on loss of lock.
  - It updates in the same cycle as the corresponding Control output.
- Undefined: the BlankCount port is absent and no counter logic is built.

## Test plan
- Aligned stream at offset 0, 8× token 0x354 then data 0x100: Locked=1 two cycles after the 8th token, Offset=0, then DataEnable=1 with PixelData=0x00.
- Stream shifted by 3 bits, SEARCH_CYCLES=16, continuous 0x2AB tokens: Offset steps 0,1,2,3 every 16 cycles, then locks at Offset=3 with Control=11.
- Stream at true offset 9 with no matching earlier offsets: Offset wraps 9→0→…→9 correctly; no out-of-range value ever appears.
- Locked, then 7 tokens and a data word repeated, LOSS_CYCLES=64: Locked drops at cycle 64, DataEnable=0, Offset unchanged.
- ResetN pulsed low mid-data while locked: all outputs 0 immediately (asynchronous), relocks after LOCK_RUN tokens.
- With TMDS_BLANK_COUNT_EN: 3 data→token transitions give BlankCount=3; without the macro the build has no BlankCount port.
